// File: rtl/tcdm_mem_adapter_if.sv
// rtl/tcdm_mem_adapter_if.sv - request, response and macro-pin bundle of the tcdm_mem_adapter
interface tcdm_mem_adapter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 4
);
    logic                  req_i;
    logic                  gnt_o;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [BE_WIDTH-1:0]   be_i;
    logic [ID_WIDTH-1:0]   id_i;

    logic                  r_valid_o;
    logic                  r_ready_i;
    logic [DATA_WIDTH-1:0] r_rdata_o;
    logic                  r_we_o;
    logic [ID_WIDTH-1:0]   r_id_o;

    logic                  mem_cen_o;
    logic                  mem_rdwen_o;
    logic [DATA_WIDTH-1:0] mem_bw_o;
    logic [ADDR_WIDTH-1:0] mem_a_o;
    logic [DATA_WIDTH-1:0] mem_d_o;
    logic [DATA_WIDTH-1:0] mem_q_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i, id_i, r_ready_i, mem_q_i,
        output gnt_o, r_valid_o, r_rdata_o, r_we_o, r_id_o,
               mem_cen_o, mem_rdwen_o, mem_bw_o, mem_a_o, mem_d_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i, id_i, r_ready_i, mem_q_i,
        input  gnt_o, r_valid_o, r_rdata_o, r_we_o, r_id_o,
               mem_cen_o, mem_rdwen_o, mem_bw_o, mem_a_o, mem_d_o
    );
endinterface

// File: rtl/tcdm_mem_adapter.sv
// rtl/tcdm_mem_adapter.sv - TCDM req/gnt front-end for a single-port SRAM macro with 2-entry response buffer
module tcdm_mem_adapter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    tcdm_mem_adapter_if.slave  bus
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  we;
        logic [ID_WIDTH-1:0]   id;
    } rsp_t;

    logic                  s1_valid;
    logic                  s1_we;
    logic [ID_WIDTH-1:0]   s1_id;

    rsp_t                  fifo_q [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;

    logic [1:0]            occupancy;
    logic                  gnt;
    logic                  handshake;
    logic                  r_valid;
    logic                  pop;
    logic                  push;
    logic                  pop_fifo;
    rsp_t                  cap_entry;
    rsp_t                  head;
    logic [DATA_WIDTH-1:0] bw_mask;

    // Grant depends only on registered state so req/ready never reach gnt combinationally.
    assign occupancy = count + {1'b0, s1_valid};
    assign gnt       = rst_ni & (occupancy < 2'd2);
    assign handshake = bus.req_i & gnt;

    assign bus.gnt_o       = gnt;
    assign bus.mem_cen_o   = ~handshake;
    assign bus.mem_rdwen_o = ~bus.we_i;
    assign bus.mem_a_o     = bus.addr_i;
    assign bus.mem_d_o     = bus.wdata_i;

    always_comb begin
        bw_mask = '0;
        for (int k = 0; k < BE_WIDTH; k++) begin
            bw_mask[8*k +: 8] = {8{bus.be_i[k] & bus.we_i}};
        end
    end
    assign bus.mem_bw_o = bw_mask;

    // Macro Q is only trusted in the cycle right after the read access.
    always_comb begin
        cap_entry.rdata = s1_we ? '0 : bus.mem_q_i;
        cap_entry.we    = s1_we;
        cap_entry.id    = s1_id;
    end

    always_comb begin
        head = '0;
        if (count != 2'd0) begin
            head = fifo_q[rd_ptr];
        end else if (s1_valid) begin
            head = cap_entry;
        end
    end

    assign r_valid       = (count != 2'd0) | s1_valid;
    assign bus.r_valid_o = r_valid;
    assign bus.r_rdata_o = head.rdata;
    assign bus.r_we_o    = head.we;
    assign bus.r_id_o    = head.id;

    assign pop      = r_valid & bus.r_ready_i;
    assign push     = s1_valid & ~((count == 2'd0) & pop);
    assign pop_fifo = pop & (count != 2'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_we    <= 1'b0;
            s1_id    <= '0;
        end else begin
            s1_valid <= handshake;
            if (handshake) begin
                s1_we <= bus.we_i;
                s1_id <= bus.id_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_fifo) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop_fifo})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; count gates every read of it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr] <= cap_entry;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && (count == 2'd2) && !pop_fifo));

endmodule

// File: tb/tb_tcdm_mem_adapter.sv
// tb/tb_tcdm_mem_adapter.sv - directed self-checking bench for tcdm_mem_adapter with an SRAM macro model
module tb_tcdm_mem_adapter;
    logic clk_i;
    logic rst_ni;

    int n_checks;
    int n_pass;

    logic [31:0] mem [1024];
    logic [31:0] q_reg;

    tcdm_mem_adapter_if bus ();

    tcdm_mem_adapter dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Macro model: Q changes to junk after any non-read cycle to expose late sampling.
    always @(posedge clk_i) begin
        if (!bus.mem_cen_o && bus.mem_rdwen_o) begin
            q_reg <= mem[bus.mem_a_o];
        end else begin
            q_reg <= 32'hBAD0_BAD0;
            if (!bus.mem_cen_o) begin
                mem[bus.mem_a_o] <= (mem[bus.mem_a_o] & ~bus.mem_bw_o) | (bus.mem_d_o & bus.mem_bw_o);
            end
        end
    end
    assign bus.mem_q_i = q_reg;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input logic [9:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input logic [3:0] id);
        bus.req_i   = req;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.wdata_i = wdata;
        bus.be_i    = be;
        bus.id_i    = id;
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic we, input logic [31:0] rdata, input logic [3:0] id);
        check({tag, "_valid"}, bus.r_valid_o, 1'b1);
        check({tag, "_we"},    bus.r_we_o,    we);
        check({tag, "_rdata"}, bus.r_rdata_o, rdata);
        check({tag, "_id"},    bus.r_id_o,    id);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        q_reg    = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;

        // Reset state with a request already pending
        rst_ni        = 1'b0;
        bus.r_ready_i = 1'b1;
        drive(1'b1, 1'b0, 10'h000, 32'h0, 4'h0, 4'h0);
        #10;
        check("rst_gnt",    bus.gnt_o,     1'b0);
        check("rst_cen",    bus.mem_cen_o, 1'b1);
        check("rst_rvalid", bus.r_valid_o, 1'b0);
        check("rst_rdata",  bus.r_rdata_o, 32'h0);
        check("rst_rid",    bus.r_id_o,    4'h0);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 4'h0);
        rst_ni = 1'b1;
        tick();
        check("post_rst_gnt", bus.gnt_o, 1'b1);

        // Write then read
        drive(1'b1, 1'b1, 10'h005, 32'hDEAD_BEEF, 4'hF, 4'h1);
        check("wr_gnt",   bus.gnt_o,       1'b1);
        check("wr_cen",   bus.mem_cen_o,   1'b0);
        check("wr_rdwen", bus.mem_rdwen_o, 1'b0);
        check("wr_bw",    bus.mem_bw_o,    32'hFFFF_FFFF);
        tick();
        drive(1'b1, 1'b0, 10'h005, 32'h0, 4'hF, 4'h2);
        check("rd_gnt",   bus.gnt_o,       1'b1);
        check("rd_rdwen", bus.mem_rdwen_o, 1'b1);
        check("rd_bw",    bus.mem_bw_o,    32'h0);
        check_rsp("wr_rsp", 1'b1, 32'h0, 4'h1);
        tick();
        drive(1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 4'h0);
        check_rsp("rd_rsp", 1'b0, 32'hDEAD_BEEF, 4'h2);
        tick();
        check("idle_rvalid", bus.r_valid_o, 1'b0);

        // Byte-enable write over a prior all-ones value
        drive(1'b1, 1'b1, 10'h0A0, 32'hFFFF_FFFF, 4'hF, 4'h3);
        tick();
        drive(1'b1, 1'b1, 10'h0A0, 32'h1122_3344, 4'h5, 4'h4);
        check("be_bw", bus.mem_bw_o, 32'h00FF_00FF);
        check("be_d",  bus.mem_d_o,  32'h1122_3344);
        check_rsp("be_pre_rsp", 1'b1, 32'h0, 4'h3);
        tick();
        drive(1'b1, 1'b0, 10'h0A0, 32'h0, 4'h0, 4'h5);
        check_rsp("be_wr_rsp", 1'b1, 32'h0, 4'h4);
        tick();
        drive(1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 4'h0);
        check_rsp("be_rd_rsp", 1'b0, 32'hFF22_FF44, 4'h5);
        tick();

        // Back-pressure: two grants then stall, drain in order, then simultaneous pop and grant
        bus.r_ready_i = 1'b0;
        drive(1'b1, 1'b0, 10'h001, 32'h0, 4'h0, 4'h6);
        check("bp_gnt1", bus.gnt_o, 1'b1);
        tick();
        drive(1'b1, 1'b0, 10'h002, 32'h0, 4'h0, 4'h7);
        check("bp_gnt2", bus.gnt_o, 1'b1);
        tick();
        drive(1'b1, 1'b0, 10'h003, 32'h0, 4'h0, 4'h8);
        check("bp_gnt3", bus.gnt_o,     1'b0);
        check("bp_cen3", bus.mem_cen_o, 1'b1);
        check_rsp("bp_head_a", 1'b0, 32'hC0DE_0001, 4'h6);
        tick();
        check("bp_gnt4", bus.gnt_o, 1'b0);
        check_rsp("bp_head_b", 1'b0, 32'hC0DE_0001, 4'h6);
        bus.r_ready_i = 1'b1;
        #1;
        check("bp_gnt_ready", bus.gnt_o, 1'b0);
        tick();
        check_rsp("bp_rsp2", 1'b0, 32'hC0DE_0002, 4'h7);
        check("bp_gnt_resume", bus.gnt_o, 1'b1);
        tick();
        drive(1'b1, 1'b0, 10'h004, 32'h0, 4'h0, 4'h9);
        check_rsp("sim_rsp3", 1'b0, 32'hC0DE_0003, 4'h8);
        check("sim_gnt", bus.gnt_o, 1'b1);
        tick();
        drive(1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 4'h0);
        check_rsp("sim_rsp4", 1'b0, 32'hC0DE_0004, 4'h9);
        tick();
        check("bp_idle", bus.r_valid_o, 1'b0);

        // Throughput: 16 back-to-back reads
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                drive(1'b1, 1'b0, 10'h010 + 10'(i), 32'h0, 4'h0, 4'(i));
                check($sformatf("tp_gnt%0d", i), bus.gnt_o, 1'b1);
            end else begin
                drive(1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 4'h0);
            end
            if (i > 0) begin
                check_rsp($sformatf("tp_rsp%0d", i - 1), 1'b0, 32'hC0DE_0010 + 32'(i - 1), 4'(i - 1));
            end
            tick();
        end
        check("tp_idle", bus.r_valid_o, 1'b0);

        // Reset with buffer full (one buffered, one in flight)
        bus.r_ready_i = 1'b0;
        drive(1'b1, 1'b0, 10'h001, 32'h0, 4'h0, 4'h1);
        tick();
        drive(1'b1, 1'b0, 10'h002, 32'h0, 4'h0, 4'h2);
        tick();
        drive(1'b1, 1'b0, 10'h003, 32'h0, 4'h0, 4'h3);
        check("mr_full_gnt", bus.gnt_o, 1'b0);
        rst_ni = 1'b0;
        #1;
        check("mr_rvalid", bus.r_valid_o, 1'b0);
        check("mr_cen",    bus.mem_cen_o, 1'b1);
        check("mr_gnt",    bus.gnt_o,     1'b0);
        tick();
        check("mr_cen_edge", bus.mem_cen_o, 1'b1);
        drive(1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 4'h0);
        rst_ni = 1'b1;
        bus.r_ready_i = 1'b1;
        #1;
        check("mr_rel_gnt",    bus.gnt_o,     1'b1);
        check("mr_rel_rvalid", bus.r_valid_o, 1'b0);
        tick();
        check("mr_stale", bus.r_valid_o, 1'b0);
        drive(1'b1, 1'b0, 10'h007, 32'h0, 4'h0, 4'hA);
        tick();
        drive(1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 4'h0);
        check_rsp("mr_fresh", 1'b0, 32'hC0DE_0007, 4'hA);
        tick();
        check("mr_end_idle", bus.r_valid_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
